// File: rtl/io_bridge.sv
// Byte-wide cpu bus bridge: decodes RAM vs. the I/O window at 0x30000 and
// implements the tx/rx byte FIFOs, cycle counter with coherent snapshot and stop flag.
module io_bridge #(
    parameter int OUT_DEPTH_LOG2 = 4,
    parameter int IN_DEPTH_LOG2  = 4
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        cpu_rdy,
    output logic [16:0] ram_a,
    output logic [7:0]  ram_dout,
    output logic        ram_we,
    input  logic [7:0]  ram_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        program_done,
    output logic        rx_overflow
);
    localparam int TX_DEPTH = 1 << OUT_DEPTH_LOG2;
    localparam int RX_DEPTH = 1 << IN_DEPTH_LOG2;
    localparam logic [17:0] A_DATA = 18'h30000;
    localparam logic [17:0] A_CNT0 = 18'h30004;

    logic [17:0] w_a;
    logic        w_io;
    logic        w_io_rd;
    logic        w_io_wr;
    logic        w_unused_a;

    assign w_a        = cpu_a[17:0];
    assign w_io       = (w_a[17:16] == 2'b11);
    assign w_io_rd    = w_io & ~cpu_wr;
    assign w_io_wr    = w_io & cpu_wr;
    assign w_unused_a = ^cpu_a[31:18];

    assign ram_a    = cpu_a[16:0];
    assign ram_dout = cpu_dout;
    assign ram_we   = cpu_wr & ~w_io;

    logic [7:0]                r_tx_mem [TX_DEPTH];
    logic [OUT_DEPTH_LOG2-1:0] r_tx_rptr;
    logic [OUT_DEPTH_LOG2-1:0] r_tx_wptr;
    logic [OUT_DEPTH_LOG2:0]   r_tx_cnt;
    logic                      w_tx_full;
    logic                      w_tx_empty;
    logic                      w_tx_req;
    logic                      w_tx_pop;
    logic                      w_tx_push;

    // Count never exceeds depth, so its MSB alone marks full.
    assign w_tx_full  = r_tx_cnt[OUT_DEPTH_LOG2];
    assign w_tx_empty = (r_tx_cnt == '0);
    assign w_tx_req   = w_io_wr & (w_a == A_DATA) & (cpu_dout != 8'h00);
    assign w_tx_pop   = ~w_tx_empty & tx_ready;
    assign w_tx_push  = w_tx_req & (~w_tx_full | w_tx_pop);
    assign tx_valid   = ~w_tx_empty;
    assign tx_data    = r_tx_mem[r_tx_rptr];

    // A same-cycle pop makes room, so the stalled write is accepted exactly
    // when cpu_rdy is high and the cpu never repeats a byte.
    assign cpu_rdy = ~(w_tx_req & w_tx_full & ~w_tx_pop);

    always_ff @(posedge clk_in) begin
        if (w_tx_push) begin
            r_tx_mem[r_tx_wptr] <= cpu_dout;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_tx_rptr <= '0;
            r_tx_wptr <= '0;
            r_tx_cnt  <= '0;
        end else begin
            if (w_tx_push) r_tx_wptr <= r_tx_wptr + OUT_DEPTH_LOG2'(1);
            if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + OUT_DEPTH_LOG2'(1);
            case ({w_tx_push, w_tx_pop})
                2'b10:   r_tx_cnt <= r_tx_cnt + (OUT_DEPTH_LOG2 + 1)'(1);
                2'b01:   r_tx_cnt <= r_tx_cnt - (OUT_DEPTH_LOG2 + 1)'(1);
                default: r_tx_cnt <= r_tx_cnt;
            endcase
        end
    end

    logic [7:0]               r_rx_mem [RX_DEPTH];
    logic [IN_DEPTH_LOG2-1:0] r_rx_rptr;
    logic [IN_DEPTH_LOG2-1:0] r_rx_wptr;
    logic [IN_DEPTH_LOG2:0]   r_rx_cnt;
    logic                     w_rx_full;
    logic                     w_rx_empty;
    logic                     w_rx_pop;
    logic                     w_rx_push;
    logic                     r_rx_ovf;

    assign w_rx_full   = r_rx_cnt[IN_DEPTH_LOG2];
    assign w_rx_empty  = (r_rx_cnt == '0);
    assign w_rx_pop    = w_io_rd & (w_a == A_DATA) & ~w_rx_empty;
    assign w_rx_push   = rx_valid & (~w_rx_full | w_rx_pop);
    assign rx_overflow = r_rx_ovf;

    always_ff @(posedge clk_in) begin
        if (w_rx_push) begin
            r_rx_mem[r_rx_wptr] <= rx_data;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_rx_rptr <= '0;
            r_rx_wptr <= '0;
            r_rx_cnt  <= '0;
            r_rx_ovf  <= 1'b0;
        end else begin
            if (w_rx_push) r_rx_wptr <= r_rx_wptr + IN_DEPTH_LOG2'(1);
            if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + IN_DEPTH_LOG2'(1);
            if (rx_valid & ~w_rx_push) r_rx_ovf <= 1'b1;
            case ({w_rx_push, w_rx_pop})
                2'b10:   r_rx_cnt <= r_rx_cnt + (IN_DEPTH_LOG2 + 1)'(1);
                2'b01:   r_rx_cnt <= r_rx_cnt - (IN_DEPTH_LOG2 + 1)'(1);
                default: r_rx_cnt <= r_rx_cnt;
            endcase
        end
    end

    logic [31:0] r_cnt;
    logic [31:0] r_snap;
    logic        r_done;

    assign program_done = r_done;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_cnt  <= 32'd0;
            r_snap <= 32'd0;
            r_done <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 32'd1;
            if (w_io_rd && (w_a == A_CNT0)) r_snap <= r_cnt;
            if (w_io_wr && (w_a == A_CNT0)) r_done <= 1'b1;
        end
    end

    logic [7:0] w_io_byte;
    logic [7:0] r_io_byte;
    logic       r_sel_ram;
    logic       r_rd_vld;

    // Byte 0 comes from the live counter, the same value the snapshot captures.
    always_comb begin
        w_io_byte = 8'h00;
        if (w_io_rd) begin
            case (w_a)
                A_DATA:    if (!w_rx_empty) w_io_byte = r_rx_mem[r_rx_rptr];
                A_CNT0:    w_io_byte = r_cnt[7:0];
                18'h30005: w_io_byte = r_snap[15:8];
                18'h30006: w_io_byte = r_snap[23:16];
                18'h30007: w_io_byte = r_snap[31:24];
                default:   w_io_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        r_io_byte <= w_io_byte;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sel_ram <= 1'b1;
            r_rd_vld  <= 1'b0;
        end else begin
            r_sel_ram <= ~w_io;
            r_rd_vld  <= ~cpu_wr;
        end
    end

    // RAM data arrives one cycle after its address, aligned with the select register.
    assign cpu_din = !r_rd_vld ? 8'h00 : (r_sel_ram ? ram_din : r_io_byte);

endmodule
